// File: rtl/uart_tx_fifo.sv
// Transmit FIFO and launch controller feeding a UART transmitter.
// Queues user bytes and hands them out one at a time, waiting for tx_done_tick between launches.
module uart_tx_fifo #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DBIT-1:0]   w_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic              tx_start,
    output logic [DBIT-1:0]   tx_din,
    input  logic              tx_done_tick,
    output logic              busy
);

    // state     | meaning
    // IDLE      | no byte in flight; launches the head byte whenever the FIFO is non-empty
    // WAIT_DONE | byte handed to the transmitter; waiting for tx_done_tick
    typedef enum logic {IDLE, WAIT_DONE} state_t;

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    state_t              state, state_next;
    logic [DBIT-1:0]     mem [DEPTH];
    logic [ADDR_W-1:0]   rd_ptr, wr_ptr;
    logic [ADDR_W:0]     count_reg;
    logic                push, pop, drop;

    assign empty  = (count_reg == '0);
    assign full   = (count_reg == FULL_CNT);
    assign count  = count_reg;
    assign tx_din = mem[rd_ptr];

    // A pop frees a slot this cycle, so a write into a full FIFO still lands
    assign pop  = tx_start;
    assign push = wr & (~full | pop);
    assign drop = wr & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count_reg <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (~empty) begin
                    tx_start   = 1'b1;
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                busy = 1'b1;
                if (tx_done_tick) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model checked every cycle, directed scenarios
// with literal expectations, then a randomized phase with a stand-in transmitter.
module tb_uart_tx_fifo;

    localparam int DBIT   = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr = 1'b0;
    logic [DBIT-1:0]   w_data = '0;
    logic              full, empty, overflow, tx_start, busy;
    logic [ADDR_W:0]   count;
    logic              clr_ovf = 1'b0;
    logic [DBIT-1:0]   tx_din;
    logic              tx_done_tick = 1'b0;

    uart_tx_fifo #(.DBIT(DBIT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .clr_ovf(clr_ovf), .tx_start(tx_start), .tx_din(tx_din),
        .tx_done_tick(tx_done_tick), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endfunction

    // Reference model: the queue contents, whether a byte is in flight, and the sticky flag
    logic [DBIT-1:0] mq[$];
    bit              m_inflight = 0;
    bit              m_ovf = 0;
    bit              cmp_en = 0;

    function automatic void model_update();
        bit launching, accept;
        if (reset) begin
            mq.delete();
            m_inflight = 0;
            m_ovf = 0;
            return;
        end
        launching = !m_inflight && mq.size() > 0;
        accept    = wr && (mq.size() < DEPTH || launching);
        if (launching) begin
            void'(mq.pop_front());
            m_inflight = 1;
        end else if (m_inflight && tx_done_tick) begin
            m_inflight = 0;
        end
        if (accept) mq.push_back(w_data);
        if (wr && !accept) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("count", int'(count), mq.size());
            chk("empty", int'(empty), int'(mq.size() == 0));
            chk("full", int'(full), int'(mq.size() == DEPTH));
            chk("busy", int'(busy), int'(m_inflight));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("tx_start", int'(tx_start), int'(!m_inflight && mq.size() > 0));
            if (!m_inflight && mq.size() > 0) chk("tx_din", int'(tx_din), int'(mq[0]));
        end
    end

    // Stand-in transmitter and launch log
    bit              auto_tx = 0;
    bit              rand_lat = 0;
    int              lat = 20;
    int              tx_cnt = 0;
    int              cyc = 0;
    logic [DBIT-1:0] log_b[$];
    int              log_c[$];

    task automatic step();
        if (reset) begin
            tx_cnt = 0;
            if (auto_tx) tx_done_tick = 1'b0;
        end else begin
            if (auto_tx) begin
                tx_done_tick = 1'b0;
                if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) tx_done_tick = 1'b1;
                end
                if (tx_start) tx_cnt = rand_lat ? int'($urandom_range(1, 6)) : lat;
            end
            if (tx_start) begin
                log_b.push_back(tx_din);
                log_c.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        model_update();
        cyc++;
        @(negedge clk);
    endtask

    task automatic write_byte(input logic [DBIT-1:0] b);
        wr = 1'b1;
        w_data = b;
        step();
        wr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        log_b.delete();
        log_c.delete();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((busy || !empty) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", int'(busy || !empty), 0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        cmp_en = 1;

        // Scenario 1: single byte from reset
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_busy", int'(busy), 0);
        write_byte(8'h41);
        chk("s1_tx_start", int'(tx_start), 1);
        chk("s1_tx_din", int'(tx_din), 'h41);
        step();
        chk("s1_busy", int'(busy), 1);
        chk("s1_empty", int'(empty), 1);
        chk("s1_count", int'(count), 0);
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;

        // Scenario 2: burst of three, transmitter done 20 clks after each launch
        log_b.delete();
        log_c.delete();
        auto_tx = 1;
        lat = 20;
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        drain(200);
        chk("s2_launches", log_b.size(), 3);
        if (log_b.size() == 3) begin
            chk("s2_byte0", int'(log_b[0]), 'h01);
            chk("s2_byte1", int'(log_b[1]), 'h02);
            chk("s2_byte2", int'(log_b[2]), 'h03);
            chk("s2_gap01", log_c[1] - log_c[0], 21);
            chk("s2_gap12", log_c[2] - log_c[1], 21);
        end
        chk("s2_count", int'(count), 0);
        for (int i = 0; i < 25; i++) step();
        auto_tx = 0;
        tx_done_tick = 1'b0;

        // Scenario 3: fill behind an in-flight byte, then overflow
        write_byte(8'hF0);
        step();
        chk("s3_busy", int'(busy), 1);
        for (int i = 0; i < 16; i++) write_byte(8'(8'h10 + i));
        chk("s3_full", int'(full), 1);
        chk("s3_count16", int'(count), 16);
        chk("s3_ovf_before", int'(overflow), 0);
        write_byte(8'hEE);
        chk("s3_ovf", int'(overflow), 1);
        chk("s3_count_after_drop", int'(count), 16);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("s3_ovf_cleared", int'(overflow), 0);

        // Scenario 4: push on the pop cycle of a full FIFO
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("s4_tx_start", int'(tx_start), 1);
        chk("s4_tx_din", int'(tx_din), 'h10);
        write_byte(8'hAA);
        chk("s4_count", int'(count), 16);
        chk("s4_full", int'(full), 1);
        chk("s4_ovf", int'(overflow), 0);
        chk("s4_busy", int'(busy), 1);

        // Scenario 5: 40 bytes through the pointers twice, order preserved
        do_reset();
        auto_tx = 1;
        lat = 3;
        for (int i = 0; i < 40; i++) begin
            write_byte(8'(i * 7 + 3));
            step();
            step();
            step();
        end
        drain(400);
        chk("s5_launches", log_b.size(), 40);
        for (int i = 0; i < 40 && i < log_b.size(); i++)
            chk("s5_order", int'(log_b[i]), (i * 7 + 3) & 'hFF);
        chk("s5_ovf", int'(overflow), 0);
        for (int i = 0; i < 6; i++) step();
        auto_tx = 0;
        tx_done_tick = 1'b0;

        // Scenario 6: reset while a byte is in flight with five queued
        for (int i = 0; i < 6; i++) write_byte(8'(8'h60 + i));
        chk("s6_pre_count", int'(count), 5);
        chk("s6_pre_busy", int'(busy), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("s6_count", int'(count), 0);
        chk("s6_empty", int'(empty), 1);
        chk("s6_busy", int'(busy), 0);
        chk("s6_tx_start", int'(tx_start), 0);
        chk("s6_ovf", int'(overflow), 0);
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("s6_stray_done_busy", int'(busy), 0);

        // Randomized traffic with random transmitter latency
        auto_tx = 1;
        rand_lat = 1;
        for (int i = 0; i < 3000; i++) begin
            wr      = ($urandom_range(0, 1) == 1);
            w_data  = 8'($urandom);
            clr_ovf = ($urandom_range(0, 19) == 0);
            reset   = ($urandom_range(0, 299) == 0);
            step();
        end
        wr = 1'b0;
        clr_ovf = 1'b0;
        reset = 1'b0;
        drain(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
